// File: rtl/bcd_seq_ctrl.sv
// Signed-byte to BCD sequencer: captures a signed value on start, converts its magnitude
// with one shift/add-3 step per clock, and publishes digits and sign together on done.
module bcd_seq_ctrl #(
   parameter int DATA_W = 8,
   parameter int DIGITS = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DATA_W-1:0]       data,
   output logic                    busy,
   output logic                    done,
   output logic [0:DIGITS-1][3:0]  bcd,
   output logic                    sign
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                   state_r;
   logic                     sign_r;
   logic [DATA_W-1:0]        mag_r;
   logic [0:DIGITS-1][3:0]   work_r;
   logic [CNT_W-1:0]         count_r;

   logic [0:DIGITS-1][3:0]   adj_s;
   logic [0:DIGITS-1][3:0]   nxt_work_s;
   logic [DATA_W-1:0]        nxt_mag_s;
   logic [DATA_W-1:0]        abs_s;

   // Magnitude kept DATA_W bits wide so the most negative value maps to 2**(DATA_W-1).
   function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
      if (v[DATA_W-1]) begin
         return ~v + DATA_W'(1);
      end else begin
         return v;
      end
   endfunction

   assign abs_s = abs_val(data);

   // One double-dabble step: correct each digit, then shift the digit/magnitude chain left.
   always_comb begin
      adj_s = work_r;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_r[i] >= 4'd5) begin
            adj_s[i] = work_r[i] + 4'd3;
         end else begin
            adj_s[i] = work_r[i];
         end
      end
      {nxt_work_s, nxt_mag_s} = {adj_s, mag_r} << 1'b1;
   end

   // Sequencer state, working registers and the held result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         sign_r  <= 1'b0;
         mag_r   <= '0;
         work_r  <= '0;
         count_r <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd     <= '0;
         sign    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sign_r  <= data[DATA_W-1];
                  mag_r   <= abs_s;
                  work_r  <= '0;
                  count_r <= '0;
                  busy    <= 1'b1;
                  state_r <= SHIFT;
               end else begin
                  busy    <= 1'b0;
               end
            end
            SHIFT: begin
               work_r  <= nxt_work_s;
               mag_r   <= nxt_mag_s;
               count_r <= count_r + CNT_W'(1);
               // Digits and sign are published together so the decoders never see a partial value.
               if (count_r == LAST) begin
                  bcd     <= nxt_work_s;
                  sign    <= sign_r;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  done    <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
